cpu_step_ctrl: RTL and testbench
================================

# cpu_step_ctrl

Execution controller between the clock divider and the single-cycle MIPS core. It turns the divider's `slow_clk` square wave into one-`clk`-cycle `cpu_en` pulses in run mode. In pause mode it issues exactly one `cpu_en` per debounced press of the step button. It stops permanently on the core's `halt` flag and counts executed instructions for the display logic.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable `clk` cycles required to accept a button level change (20 ms at 50 MHz).
- `CNT_W`, default 32: width of `cycle_count`.

Ports:
- `clk`  in  1  system clock, 50 MHz.
- `reset`  in  1  reset; asynchronous, active-high.
- `slow_clk`  in  1  clock-divider output; registered in the `clk` domain, so it needs no synchronizer.
- `btn_step`  in  1  raw, asynchronous, bouncing step button; active-high.
- `btn_run`  in  1  raw, asynchronous, bouncing run/pause toggle button; active-high.
- `halt`  in  1  core halt flag; `clk` domain, level.
- `cpu_en`  out  1  registered, one-cycle instruction enable to the core.
- `running`  out  1  1 when state is RUN.
- `halted`  out  1  1 when state is HALTED.
- `cycle_count`  out  `CNT_W`  number of `cpu_en` pulses issued since reset.

## Operation
- **Button path** (`btn_step` and `btn_run` each get an independent copy):
  - 2-flop synchronizer produces `s2`.
  - Debounce counter `dc` (`clog2(DEBOUNCE_CYCLES)` bits) and debounced level `db`.
  - If `s2 == db`: `dc <= 0`.
  - Else if `dc == DEBOUNCE_CYCLES-1`: `db <= s2` and `dc <= 0`.
  - Else: `dc <= dc + 1`.
  - `press = db & ~db_d`: combinational, one cycle long, rising edge only. Releases generate no event.
- **Tick detect:** `slow_d <= slow_clk`; `tick = slow_clk & ~slow_d`. Only rising edges count.
- **FSM:** PAUSE is the reset state.
  - PAUSE, `halt`=1 → HALTED, no pulse.
  - PAUSE, else `run_press` → RUN.
  - PAUSE, else `step_press` → `cpu_en <= 1`, stay in PAUSE.
  - RUN, `halt`=1 → HALTED, no pulse.
  - RUN, else `run_press` → PAUSE, no pulse even if `tick` is set in the same cycle.
  - RUN, else `tick` → `cpu_en <= 1`.
  - HALTED: `cpu_en` stays 0 and all presses and ticks are ignored. Only `reset` exits.
- **Priority in every state:** `halt` > `run_press` > `step_press`/`tick`. `step_press` is ignored in RUN; `tick` is ignored in PAUSE.
- **`cpu_en`:** registered, deasserted in every cycle with no qualifying event. Pulses can never be back-to-back, because `tick` and `press` need a prior 0 level.
- **`cycle_count`:** increments by 1 on each edge where `cpu_en` = 1. Wraps from all-ones to 0 silently. Not cleared by pause or halt.
- **Reset values** (any time, including mid-debounce or mid-pulse): `cpu_en`=0, `running`=0, `halted`=0, `cycle_count`=0, state PAUSE. Internal `db`, `db_d`, `dc`, `s1`, `s2` and `slow_d` are all 0.
- **Button held through reset release:** counted as one fresh press once it has been stable for `DEBOUNCE_CYCLES`.

## Timing
- **Button latency:** let edge 0 be the first `clk` edge sampling the raw button at 1, held stable.
  - `s2` = 1 after edge 1.
  - `db` = 1 after edge `DEBOUNCE_CYCLES+1`.
  - `cpu_en` = 1 between edges `DEBOUNCE_CYCLES+2` and `DEBOUNCE_CYCLES+3`.
- **Bounce rejection:** any return of `s2` to `db` before the count completes resets `dc`. A glitch shorter than `DEBOUNCE_CYCLES` cycles never changes `db`.
- **Tick latency:** if `slow_clk` rises after edge T, `cpu_en` is high between edges T+1 and T+2. That is one pulse per `slow_clk` period.
- **Halt:** `halt` sampled high at edge H blocks any `cpu_en` from edge H onward. `halted` is 1 after edge H.
- **Count:** `cycle_count` updates on the edge that ends each `cpu_en` pulse.

## Test plan
Bench uses `DEBOUNCE_CYCLES`=4 and `CNT_W`=8.
1. **Reset, then single step:** reset, then hold `btn_step`=1 from edge 0.
   - `cpu_en` is high only between edges 6 and 7.
   - `cycle_count` = 1 after edge 7; `running` = 0.
2. **Bounce rejection:** toggle `btn_step` 1,1,1,0 repeatedly for 40 cycles, then release.
   - `cpu_en` stays 0; `cycle_count` stays 0.
3. **Run mode:** press `btn_run`, then drive `slow_clk` with period 10 for 5 periods.
   - `running` = 1; 5 one-cycle `cpu_en` pulses, each 1 cycle after a `slow_clk` rise.
   - `cycle_count` = 5.
   - Then press `btn_run` again: `running` = 0 and no further pulses.
4. **Pause vs tick collision:** in RUN, align the debounced `run_press` with a `slow_clk` rise.
   - No `cpu_en`; state becomes PAUSE.
5. **Halt:**
   - In RUN, assert `halt` on the same edge as a tick: no pulse; `halted` = 1.
   - Further step/run presses and ticks produce no `cpu_en`.
   - `reset` returns to PAUSE with `halted` = 0.
6. **Wrap and mid-operation reset:**
   - Issue 257 steps: `cycle_count` = 1 after wrapping.
   - Assert `reset` during a `cpu_en`-high cycle: `cpu_en` and `cycle_count` go to 0 immediately, asynchronously.

Source files
------------

// File: rtl/cpu_step_ctrl.sv
// Execution controller for the single-cycle MIPS core: run/pause/step/halt
// sequencing, button debouncing and an executed-instruction counter.
module cpu_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             slow_clk,
  input  logic             btn_step,
  input  logic             btn_run,
  input  logic             halt,
  output logic             cpu_en,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int DC_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DC_W-1:0] DC_MAX = DC_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    PAUSE  = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t          state;
  logic [1:0]      btn_raw;
  logic [1:0]      s1;
  logic [1:0]      s2;
  logic [1:0]      db;
  logic [1:0]      db_d;
  logic [DC_W-1:0] dc [2];
  logic [1:0]      press;
  logic            step_press;
  logic            run_press;
  logic            slow_d;
  logic            tick;

  // Index 0 is the step button, index 1 the run/pause button.
  assign btn_raw = {btn_run, btn_step};

  // Synchronizer and debounce: db only follows s2 after DEBOUNCE_CYCLES
  // consecutive cycles of disagreement; any agreement restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1   <= '0;
      s2   <= '0;
      db   <= '0;
      db_d <= '0;
      for (int i = 0; i < 2; i++) dc[i] <= '0;
    end else begin
      s1   <= btn_raw;
      s2   <= s1;
      db_d <= db;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == db[i]) begin
          dc[i] <= '0;
        end else if (dc[i] == DC_MAX) begin
          db[i] <= s2[i];
          dc[i] <= '0;
        end else begin
          dc[i] <= dc[i] + DC_W'(1);
        end
      end
    end
  end

  assign press      = db & ~db_d;
  assign step_press = press[0];
  assign run_press  = press[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) slow_d <= 1'b0;
    else       slow_d <= slow_clk;
  end

  assign tick = slow_clk & ~slow_d;

  // Control FSM: halt beats run_press, which beats step_press/tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= PAUSE;
      cpu_en      <= 1'b0;
      running     <= 1'b0;
      halted      <= 1'b0;
      cycle_count <= '0;
    end else begin
      cpu_en <= 1'b0;
      if (cpu_en) cycle_count <= cycle_count + CNT_W'(1);
      case (state)
        PAUSE: begin
          if (halt) begin
            state  <= HALTED;
            halted <= 1'b1;
          end else if (run_press) begin
            state   <= RUN;
            running <= 1'b1;
          end else if (step_press) begin
            cpu_en <= 1'b1;
          end
        end
        RUN: begin
          if (halt) begin
            state   <= HALTED;
            running <= 1'b0;
            halted  <= 1'b1;
          end else if (run_press) begin
            state   <= PAUSE;
            running <= 1'b0;
          end else if (tick) begin
            cpu_en <= 1'b1;
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state   <= PAUSE;
          running <= 1'b0;
          halted  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Scoreboard bench for cpu_step_ctrl: expected cpu_en pulse cycles are queued
// as stimulus is driven and matched against every observed pulse.
module tb_cpu_step_ctrl;

  localparam int DEB = 4;
  localparam int CW  = 8;

  logic          clk      = 1'b0;
  logic          reset    = 1'b0;
  logic          slow_clk = 1'b0;
  logic          btn_step = 1'b0;
  logic          btn_run  = 1'b0;
  logic          halt     = 1'b0;
  logic          cpu_en;
  logic          running;
  logic          halted;
  logic [CW-1:0] cycle_count;

  int            checks = 0;
  int            errors = 0;
  int            cyc    = 0;
  int            exp_q[$];
  logic [CW-1:0] exp_cnt = '0;

  cpu_step_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .slow_clk   (slow_clk),
    .btn_step   (btn_step),
    .btn_run    (btn_run),
    .halt       (halt),
    .cpu_en     (cpu_en),
    .running    (running),
    .halted     (halted),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every observed pulse must match the oldest expected pulse cycle.
  always @(negedge clk) begin : monitor
    int e;
    if (!reset && cpu_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cyc=%0d got cpu_en=1 required 0", cyc);
      end else begin
        e = exp_q.pop_front();
        if (e != cyc) begin
          errors++;
          $display("FAIL pulse_time got cyc=%0d required cyc=%0d", cyc, e);
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_btn(input bit is_run);
    if (is_run) btn_run = 1'b1; else btn_step = 1'b1;
    wait_cyc(8);
    if (is_run) btn_run = 1'b0; else btn_step = 1'b0;
    wait_cyc(8);
  endtask

  task automatic tick_period();
    slow_clk = 1'b1;
    wait_cyc(5);
    slow_clk = 1'b0;
    wait_cyc(5);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    slow_clk = 1'b0;
    btn_step = 1'b0;
    btn_run  = 1'b0;
    halt     = 1'b0;
    exp_q.delete();
    exp_cnt  = '0;
    wait_cyc(2);
    reset = 1'b0;
    wait_cyc(1);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (cpu_en !== 1'b0) begin errors++; $display("FAIL reset_cpu_en got %b required 0", cpu_en); end
    checks++;
    if (running !== 1'b0) begin errors++; $display("FAIL reset_running got %b required 0", running); end
    checks++;
    if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b required 0", halted); end
    checks++;
    if (cycle_count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d required 0", cycle_count); end
    wait_cyc(2);
    reset = 1'b0;
    wait_cyc(4);
    checks++;
    if (running !== 1'b0 || halted !== 1'b0 || cycle_count !== 8'd0) begin
      errors++;
      $display("FAIL post_reset_idle got run=%b halt=%b cnt=%0d required 0 0 0", running, halted, cycle_count);
    end
  endtask

  task automatic test_single_step();
    int c;
    do_reset();
    c = cyc;
    exp_q.push_back(c + 7);
    exp_cnt++;
    btn_step = 1'b1;
    wait_cyc(8);
    checks++;
    if (cycle_count !== exp_cnt) begin errors++; $display("FAIL step_count got %0d required %0d", cycle_count, exp_cnt); end
    checks++;
    if (running !== 1'b0) begin errors++; $display("FAIL step_running got %b required 0", running); end
    btn_step = 1'b0;
    wait_cyc(8);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL step_missing got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_bounce();
    do_reset();
    for (int i = 0; i < 40; i++) begin
      btn_step = (i % 4 != 3);
      wait_cyc(1);
    end
    btn_step = 1'b0;
    wait_cyc(10);
    checks++;
    if (cycle_count !== 8'd0) begin errors++; $display("FAIL bounce_count got %0d required 0", cycle_count); end
  endtask

  task automatic test_run();
    do_reset();
    press_btn(1'b1);
    checks++;
    if (running !== 1'b1) begin errors++; $display("FAIL run_enter got %b required 1", running); end
    press_btn(1'b0);
    checks++;
    if (cycle_count !== 8'd0 || running !== 1'b1) begin
      errors++;
      $display("FAIL run_step_ignored got cnt=%0d run=%b required 0 1", cycle_count, running);
    end
    for (int p = 0; p < 5; p++) begin
      exp_q.push_back(cyc + 1);
      exp_cnt++;
      tick_period();
    end
    checks++;
    if (cycle_count !== exp_cnt) begin errors++; $display("FAIL run_count got %0d required %0d", cycle_count, exp_cnt); end
    press_btn(1'b1);
    checks++;
    if (running !== 1'b0) begin errors++; $display("FAIL run_exit got %b required 0", running); end
    for (int p = 0; p < 3; p++) tick_period();
    checks++;
    if (cycle_count !== exp_cnt) begin errors++; $display("FAIL pause_count got %0d required %0d", cycle_count, exp_cnt); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL run_missing got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_collision();
    do_reset();
    press_btn(1'b1);
    checks++;
    if (running !== 1'b1) begin errors++; $display("FAIL coll_enter got %b required 1", running); end
    fork
      press_btn(1'b1);
      begin
        wait_cyc(6);
        slow_clk = 1'b1;
        wait_cyc(5);
        slow_clk = 1'b0;
      end
    join
    checks++;
    if (running !== 1'b0) begin errors++; $display("FAIL coll_pause got %b required 0", running); end
    tick_period();
    checks++;
    if (cycle_count !== 8'd0) begin errors++; $display("FAIL coll_count got %0d required 0", cycle_count); end
  endtask

  task automatic test_halt();
    do_reset();
    press_btn(1'b1);
    exp_q.push_back(cyc + 1);
    exp_cnt++;
    tick_period();
    halt     = 1'b1;
    slow_clk = 1'b1;
    wait_cyc(1);
    checks++;
    if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag got %b required 1", halted); end
    checks++;
    if (running !== 1'b0) begin errors++; $display("FAIL halt_running got %b required 0", running); end
    halt = 1'b0;
    wait_cyc(4);
    slow_clk = 1'b0;
    wait_cyc(5);
    press_btn(1'b0);
    press_btn(1'b1);
    tick_period();
    tick_period();
    checks++;
    if (cycle_count !== exp_cnt) begin errors++; $display("FAIL halt_count got %0d required %0d", cycle_count, exp_cnt); end
    checks++;
    if (halted !== 1'b1 || running !== 1'b0) begin
      errors++;
      $display("FAIL halt_sticky got halt=%b run=%b required 1 0", halted, running);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL halt_missing got %0d pending required 0", exp_q.size()); end
    reset = 1'b1;
    #1;
    checks++;
    if (halted !== 1'b0 || running !== 1'b0 || cycle_count !== 8'd0) begin
      errors++;
      $display("FAIL halt_reset got halt=%b run=%b cnt=%0d required 0 0 0", halted, running, cycle_count);
    end
    wait_cyc(2);
    reset = 1'b0;
    wait_cyc(1);
  endtask

  task automatic test_wrap();
    int c;
    do_reset();
    for (int i = 0; i < 257; i++) begin
      exp_q.push_back(cyc + 7);
      exp_cnt++;
      press_btn(1'b0);
      if (i == 255) begin
        checks++;
        if (cycle_count !== exp_cnt) begin errors++; $display("FAIL wrap_zero got %0d required %0d", cycle_count, exp_cnt); end
      end
    end
    checks++;
    if (cycle_count !== 8'd1) begin errors++; $display("FAIL wrap_one got %0d required 1", cycle_count); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_missing got %0d pending required 0", exp_q.size()); end
    c = cyc;
    exp_q.push_back(c + 7);
    btn_step = 1'b1;
    wait_cyc(7);
    checks++;
    if (cpu_en !== 1'b1) begin errors++; $display("FAIL midreset_pre got cpu_en=%b required 1", cpu_en); end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (cpu_en !== 1'b0) begin errors++; $display("FAIL midreset_en got %b required 0", cpu_en); end
    checks++;
    if (cycle_count !== 8'd0) begin errors++; $display("FAIL midreset_count got %0d required 0", cycle_count); end
    btn_step = 1'b0;
    exp_q.delete();
    wait_cyc(2);
    reset = 1'b0;
    wait_cyc(12);
    checks++;
    if (cycle_count !== 8'd0) begin errors++; $display("FAIL postreset_count got %0d required 0", cycle_count); end
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_bounce();
    test_run();
    test_collision();
    test_halt();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
